sha1_multiblock: RTL and testbench

Parametrised SHA-1 compression engine that hashes messages of any number of pre-padded 512-bit blocks, chaining the intermediate hash between blocks. It has a valid/ready block input and a registered digest output. It uses a rolling 16-word message schedule and performs UNROLL rounds per clock. It sits between the block feeder/padder and the digest consumer, and supersedes the single-block SHA-1 core.

---
 rtl/sha1_pkg.sv | 49 ++++
 rtl/sha1_round.sv | 29 ++
 rtl/sha1_multiblock.sv | 166 ++++++++++++++++
 tb/tb_sha1_multiblock.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, FSM state type and round helper functions
// used by the multi-block compression engine.
package sha1_pkg;

  // Packed so that IV[i] is Hi; H0 sits in the lowest slot.
  localparam logic [4:0][31:0] IV = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE,
                                     32'hEFCDAB89, 32'h67452301};

  localparam logic [31:0] K0 = 32'h5A827999;
  localparam logic [31:0] K1 = 32'h6ED9EBA1;
  localparam logic [31:0] K2 = 32'h8F1BBCDC;
  localparam logic [31:0] K3 = 32'hCA62C1D6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUND  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] f(input logic [6:0] round, input logic [31:0] b,
                                    input logic [31:0] c, input logic [31:0] d);
    if (round < 7'd20) begin
      return (b & c) | (~b & d);
    end else if (round < 7'd40) begin
      return b ^ c ^ d;
    end else if (round < 7'd60) begin
      return (b & c) | (b & d) | (c & d);
    end else begin
      return b ^ c ^ d;
    end
  endfunction

  function automatic logic [31:0] k_of(input logic [6:0] round);
    if (round < 7'd20) begin
      return K0;
    end else if (round < 7'd40) begin
      return K1;
    end else if (round < 7'd60) begin
      return K2;
    end else begin
      return K3;
    end
  endfunction

endpackage

// File: rtl/sha1_round.sv
// One combinational SHA-1 round: takes the working variables, the
// schedule word and the round number, and produces the next a..e.
module sha1_round
  import sha1_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] e,
  input  logic [31:0] w,
  input  logic [6:0]  t,
  output logic [31:0] next_a,
  output logic [31:0] next_b,
  output logic [31:0] next_c,
  output logic [31:0] next_d,
  output logic [31:0] next_e
);

  logic [31:0] temp;

  assign temp   = rotl(a, 5'd5) + f(t, b, c, d) + e + k_of(t) + w;
  assign next_a = temp;
  assign next_b = a;
  assign next_c = rotl(b, 5'd30);
  assign next_d = c;
  assign next_e = d;

endmodule

// File: rtl/sha1_multiblock.sv
// Multi-block SHA-1 engine: accepts pre-padded 512-bit blocks, runs UNROLL
// rounds per clock from a rolling 16-word schedule, and chains the hash.
module sha1_multiblock
  import sha1_pkg::*;
#(
  parameter int UNROLL    = 1,
  parameter int IDX_WIDTH = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               on,
  input  logic               block_valid,
  output logic               block_ready,
  input  logic               block_first,
  input  logic [511:0]       block_in,
  output logic [159:0]       digest,
  output logic               digest_valid,
  output logic               busy,
  output logic [IDX_WIDTH:0] idx
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 5)) begin : g_bad_unroll
    $error("sha1_multiblock: UNROLL must be 1, 2, 4 or 5");
  end
  if (IDX_WIDTH < 6) begin : g_bad_idx
    $error("sha1_multiblock: IDX_WIDTH must be at least 6");
  end

  localparam int IW = IDX_WIDTH + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(80 - UNROLL);
  localparam logic [IW-1:0] STEP     = IW'(UNROLL);

  state_t            state, state_next;
  logic [4:0][31:0]  h, chain, work;
  logic [31:0]       wbuf  [16];
  logic [31:0]       wnext [16];
  logic [31:0]       w_rnd [UNROLL];
  logic [IW-1:0]     rnd_idx;
  logic              handshake;
  logic [31:0]       ra [UNROLL+1];
  logic [31:0]       rb [UNROLL+1];
  logic [31:0]       rc [UNROLL+1];
  logic [31:0]       rd [UNROLL+1];
  logic [31:0]       re [UNROLL+1];

  assign block_ready = (state == IDLE) && on && !reset;
  assign handshake   = block_valid && block_ready;
  assign busy        = (state == ROUND);
  assign idx         = busy ? rnd_idx : {IW{1'b0}};
  assign digest      = {h[0], h[1], h[2], h[3], h[4]};

  // Next-state logic; dropping the enable abandons the block from any state.
  always_comb begin
    state_next = state;
    if (!on) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) state_next = ROUND;
          else           state_next = IDLE;
        end
        ROUND: begin
          if (rnd_idx == LAST_IDX) state_next = UPDATE;
          else                     state_next = ROUND;
        end
        UPDATE:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Schedule expansion for this cycle's rounds; later words may depend on
  // words produced earlier in the same cycle, so the buffer is updated in order.
  always_comb begin
    logic [3:0]    t4;
    logic [IW-1:0] tfull;
    wnext = wbuf;
    w_rnd = '{default: 32'h0};
    t4    = 4'd0;
    tfull = {IW{1'b0}};
    for (int j = 0; j < UNROLL; j++) begin
      tfull = rnd_idx + IW'(j);
      t4    = tfull[3:0];
      if (tfull >= IW'(16)) begin
        wnext[t4] = rotl(wnext[t4 - 4'd3] ^ wnext[t4 - 4'd8] ^
                         wnext[t4 - 4'd14] ^ wnext[t4], 5'd1);
      end else begin
        wnext[t4] = wnext[t4];
      end
      w_rnd[j] = wnext[t4];
    end
  end

  assign ra[0] = work[0];
  assign rb[0] = work[1];
  assign rc[0] = work[2];
  assign rd[0] = work[3];
  assign re[0] = work[4];

  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    sha1_round u_round (
      .a      (ra[j]),
      .b      (rb[j]),
      .c      (rc[j]),
      .d      (rd[j]),
      .e      (re[j]),
      .w      (w_rnd[j]),
      .t      (7'(rnd_idx + IW'(j))),
      .next_a (ra[j+1]),
      .next_b (rb[j+1]),
      .next_c (rc[j+1]),
      .next_d (rd[j+1]),
      .next_e (re[j+1])
    );
  end

  // Datapath: block load, round updates, chaining-value update and digest flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      h            <= IV;
      chain        <= IV;
      work         <= IV;
      wbuf         <= '{default: 32'h0};
      rnd_idx      <= {IW{1'b0}};
      digest_valid <= 1'b0;
    end else if (!on) begin
      rnd_idx      <= {IW{1'b0}};
      digest_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            for (int i = 0; i < 16; i++) wbuf[i] <= block_in[511-32*i -: 32];
            chain        <= block_first ? IV : h;
            work         <= block_first ? IV : h;
            rnd_idx      <= {IW{1'b0}};
            digest_valid <= 1'b0;
          end
        end
        ROUND: begin
          work[0] <= ra[UNROLL];
          work[1] <= rb[UNROLL];
          work[2] <= rc[UNROLL];
          work[3] <= rd[UNROLL];
          work[4] <= re[UNROLL];
          wbuf    <= wnext;
          rnd_idx <= rnd_idx + STEP;
        end
        UPDATE: begin
          for (int i = 0; i < 5; i++) h[i] <= chain[i] + work[i];
          digest_valid <= 1'b1;
          rnd_idx      <= {IW{1'b0}};
        end
        default: rnd_idx <= {IW{1'b0}};
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_multiblock.sv
// Bench for sha1_multiblock: four instances (UNROLL 1, 2, 4, 5) each fed by its
// own scenario, checked every cycle against a cycle-count/digest reference model.
module tb_sha1_multiblock;

  localparam logic [159:0] IV_D  = 160'h67452301efcdab8998badcfe10325476c3d2e1f0;
  localparam logic [159:0] D_ABC = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
  localparam logic [159:0] D_EMP = 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;
  localparam logic [159:0] D_TWO = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;
  localparam logic [511:0] B_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B_EMP = {32'h80000000, 480'h0};
  localparam logic [447:0] MSG   = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
  localparam logic [511:0] B_T1  = {MSG, 8'h80, 56'h0};
  localparam logic [511:0] B_T2  = {448'h0, 64'h1C0};

  localparam int UL  [4] = '{1, 2, 4, 5};
  localparam int NB  [4] = '{80, 40, 20, 16};
  localparam int LAT [4] = '{81, 41, 21, 17};
  localparam int GAP [4] = '{82, 42, 22, 18};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         on_s [4];
  logic         bv   [4];
  logic         bf   [4];
  logic [511:0] bin  [4];
  logic         brdy [4];
  logic [159:0] dig  [4];
  logic         dv   [4];
  logic         busy [4];
  logic [6:0]   idx  [4];

  logic [159:0] exp_lit [4];
  bit           lit_en  [4];
  bit           gap_en  [4];
  bit           tmo     [4];
  bit           done    [4];
  bit           wd = 1'b0;

  int           total = 0;
  int           bad = 0;
  int           nprint = 0;

  // model state
  int           cyc = 0;
  int           cnt    [4] = '{default: 0};
  logic [159:0] m_h    [4] = '{default: IV_D};
  logic [159:0] m_next [4] = '{default: IV_D};
  logic         m_dv   [4] = '{default: 1'b0};
  logic         m_hs   [4] = '{default: 1'b0};

  always #5 clk = ~clk;

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Textbook SHA-1 compression with a full 80-word schedule.
  function automatic logic [159:0] sha1_ref(input logic [159:0] hin, input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, fv, k, tmp;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 80; t++) w[t] = rl(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
    a = hin[159:128]; b = hin[127:96]; c = hin[95:64]; d = hin[63:32]; e = hin[31:0];
    for (int t = 0; t < 80; t++) begin
      case (t / 20)
        0:       begin fv = (b & c) | (~b & d);          k = 32'h5A827999; end
        1:       begin fv = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
        2:       begin fv = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
        default: begin fv = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      endcase
      tmp = rl(a, 5) + fv + e + k + w[t];
      e = d; d = c; c = rl(b, 30); b = a; a = tmp;
    end
    return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
  endfunction

  // Reference model: a block takes N busy cycles, one update cycle, then commits.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 4; g++) begin
      m_hs[g] <= 1'b0;
      if (reset) begin
        cnt[g] <= 0; m_h[g] <= IV_D; m_dv[g] <= 1'b0;
      end else if (!on_s[g]) begin
        cnt[g] <= 0; m_dv[g] <= 1'b0;
      end else if (cnt[g] == 0) begin
        if (bv[g]) begin
          m_next[g] <= sha1_ref(bf[g] ? IV_D : m_h[g], bin[g]);
          m_dv[g]   <= 1'b0;
          cnt[g]    <= 1;
          m_hs[g]   <= 1'b1;
        end
      end else if (cnt[g] == NB[g] + 1) begin
        m_h[g] <= m_next[g]; m_dv[g] <= 1'b1; cnt[g] <= 0;
      end else begin
        cnt[g] <= cnt[g] + 1;
      end
    end
  end

  task automatic check(input string nm, input int g, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (nprint < 40) $display("FAIL %s u=%0d cyc=%0d got=%h want=%h", nm, UL[g], cyc, act, exp);
      nprint++;
    end
  endtask

  // Single compare process: model pins, reset values, then every-cycle checks.
  initial begin
    int  last_hs [4];
    int  bcnt    [4];
    bit  pdv     [4];
    bit  dseen   [4];
    bit  wdseen;
    logic exp_busy, exp_rdy;
    logic [6:0] exp_idx;
    last_hs = '{default: 0}; bcnt = '{default: 0}; pdv = '{default: 1'b0};
    dseen = '{default: 1'b0}; wdseen = 1'b0;
    @(negedge clk);
    check("pin_abc", 0, sha1_ref(IV_D, B_ABC), D_ABC);
    check("pin_empty", 0, sha1_ref(IV_D, B_EMP), D_EMP);
    check("pin_two", 0, sha1_ref(sha1_ref(IV_D, B_T1), B_T2), D_TWO);
    for (int g = 0; g < 4; g++) begin
      check("reset_digest", g, dig[g], IV_D);
      check("reset_ready", g, 160'(brdy[g]), 160'(1'b0));
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        exp_busy = (cnt[g] >= 1) && (cnt[g] <= NB[g]);
        exp_idx  = exp_busy ? 7'((cnt[g] - 1) * UL[g]) : 7'd0;
        exp_rdy  = (cnt[g] == 0) && on_s[g] && !reset;
        check("ready", g, 160'(brdy[g]), 160'(exp_rdy));
        check("busy", g, 160'(busy[g]), 160'(exp_busy));
        check("idx", g, 160'(idx[g]), 160'(exp_idx));
        check("digest_valid", g, 160'(dv[g]), 160'(m_dv[g]));
        check("digest", g, dig[g], m_h[g]);
        if (m_hs[g]) begin
          if (gap_en[g]) check("hs_gap", g, 160'(cyc - last_hs[g]), 160'(GAP[g]));
          last_hs[g] = cyc;
          bcnt[g] = 0;
        end
        if (busy[g]) bcnt[g]++;
        if (dv[g] && !pdv[g]) begin
          check("latency", g, 160'(cyc - last_hs[g]), 160'(LAT[g]));
          check("busy_cycles", g, 160'(bcnt[g]), 160'(NB[g]));
          if (lit_en[g]) check("known_digest", g, dig[g], exp_lit[g]);
        end
        pdv[g] = dv[g];
        if (done[g] && !dseen[g]) begin
          dseen[g] = 1'b1;
          check("no_timeout", g, 160'(tmo[g]), 160'(1'b0));
        end
      end
      if (wd && !wdseen) begin
        wdseen = 1'b1;
        check("watchdog", 0, 160'(wd), 160'(1'b0));
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : fd
    sha1_multiblock #(.UNROLL(UL[g]), .IDX_WIDTH(6)) dut (
      .clk          (clk),
      .reset        (reset),
      .on           (on_s[g]),
      .block_valid  (bv[g]),
      .block_ready  (brdy[g]),
      .block_first  (bf[g]),
      .block_in     (bin[g]),
      .digest       (dig[g]),
      .digest_valid (dv[g]),
      .busy         (busy[g]),
      .idx          (idx[g])
    );

    task automatic send(input logic [511:0] blk, input logic first, input bit hold);
      int budget = 0;
      bin[g] = blk; bf[g] = first; bv[g] = 1'b1;
      while (!brdy[g] && budget < 400) begin @(posedge clk); #1; budget++; end
      if (budget >= 400) tmo[g] = 1'b1;
      @(posedge clk); #1;
      if (!hold) bv[g] = 1'b0;
    endtask

    task automatic wait_done();
      int budget = 0;
      while (!dv[g] && budget < 400) begin @(posedge clk); #1; budget++; end
      if (budget >= 400) tmo[g] = 1'b1;
      @(posedge clk); #1;
    endtask

    initial begin
      logic [511:0] rblk;
      int budget;
      on_s[g] = 1'b1; bv[g] = 1'b0; bf[g] = 1'b0; bin[g] = 512'h0;
      lit_en[g] = 1'b0; gap_en[g] = 1'b0; tmo[g] = 1'b0; done[g] = 1'b0; exp_lit[g] = D_ABC;
      wait (reset == 1'b0);
      @(posedge clk); #1;
      // first block after reset with first=0 chains from the IV
      exp_lit[g] = D_ABC; lit_en[g] = 1'b1;
      send(B_ABC, 1'b0, 1'b0); wait_done();
      send(B_ABC, 1'b1, 1'b0); wait_done();
      exp_lit[g] = D_EMP;
      send(B_EMP, 1'b1, 1'b0); wait_done();
      lit_en[g] = 1'b0;
      send(B_T1, 1'b1, 1'b0); wait_done();
      exp_lit[g] = D_TWO; lit_en[g] = 1'b1;
      send(B_T2, 1'b0, 1'b0); wait_done();
      // abort part-way through, then restart cleanly
      exp_lit[g] = D_ABC;
      send(B_ABC, 1'b1, 1'b0);
      budget = 0;
      while (idx[g] < 7'd30 && budget < 200) begin @(posedge clk); #1; budget++; end
      if (budget >= 200) tmo[g] = 1'b1;
      on_s[g] = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      on_s[g] = 1'b1;
      send(B_ABC, 1'b1, 1'b0); wait_done();
      // back-to-back with valid held across completion
      send(B_ABC, 1'b1, 1'b1);
      @(negedge clk); #1;
      gap_en[g] = 1'b1;
      send(B_ABC, 1'b1, 1'b0); wait_done();
      gap_en[g] = 1'b0; lit_en[g] = 1'b0;
      for (int r = 0; r < 6; r++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        for (int i = 0; i < 16; i++) rblk[511-32*i -: 32] = $urandom;
        send(rblk, (r == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
        wait_done();
      end
      done[g] = 1'b1;
    end
  end

  initial begin
    int waited = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    while (!(done[0] && done[1] && done[2] && done[3]) && waited < 20000) begin
      @(posedge clk); waited++;
    end
    if (waited >= 20000) wd = 1'b1;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
